// File: rtl/lc2k_pkg.sv
// Shared LC2K core definitions: default datapath sizes, register/word types
// and the instruction opcode encodings used by decode.
package lc2k_pkg;

  localparam int LC2K_DATA_W   = 32;
  localparam int LC2K_NUM_REGS = 8;
  localparam int LC2K_ADDR_W   = $clog2(LC2K_NUM_REGS);

  typedef logic [LC2K_ADDR_W-1:0] reg_addr_t;
  typedef logic [LC2K_DATA_W-1:0] word_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_NOR  = 3'd1,
    OP_LW   = 3'd2,
    OP_SW   = 3'd3,
    OP_BEQ  = 3'd4,
    OP_JALR = 3'd5,
    OP_HALT = 3'd6,
    OP_NOOP = 3'd7
  } opcode_t;

endpackage

// File: rtl/lc2k_scoreboard.sv
// Per-register busy bits tracking in-flight producers. Issue sets, writeback
// clears, and an issue on the same edge as a writeback to that register wins
// because it names the newer producer.
module lc2k_scoreboard
  import lc2k_pkg::*;
#(
  parameter int NUM_REGS = LC2K_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_en,
  input  logic [ADDR_W-1:0]   issue_addr,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic                any_busy
);

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_bit
    if (ZERO_REG != 0 && r == 0) begin : g_zero
      // hardwired zero register never has a producer
      assign busy[r] = 1'b0;
    end else begin : g_live
      // set on issue, clear on writeback; issue takes priority
      always_ff @(posedge clk) begin
        if (reset)
          busy[r] <= 1'b0;
        else if (issue_en && issue_addr == ADDR_W'(r))
          busy[r] <= 1'b1;
        else if (wr_en && wr_addr == ADDR_W'(r))
          busy[r] <= 1'b0;
      end
    end
  end

  assign any_busy = |busy;

endmodule

// File: rtl/lc2k_regfile_sb.sv
// LC2K register file with busy scoreboard: two combinational read ports,
// one synchronous write port, a debug read port (never bypassed).
// Optional same-cycle write-to-read forwarding: LC2K_REGFILE_WRITE_BYPASS_EN.
module lc2k_regfile_sb
  import lc2k_pkg::*;
#(
  parameter int DATA_W   = LC2K_DATA_W,
  parameter int NUM_REGS = LC2K_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              any_busy
);

  logic [NUM_REGS-1:0][DATA_W-1:0] rf;
  logic [NUM_REGS-1:0]             busy_vec;
  logic                            zero_a, zero_b, zero_dbg, zero_wr;

  assign zero_a   = (ZERO_REG != 0) && (rd_addr_a == '0);
  assign zero_b   = (ZERO_REG != 0) && (rd_addr_b == '0);
  assign zero_dbg = (ZERO_REG != 0) && (dbg_addr  == '0);
  assign zero_wr  = (ZERO_REG != 0) && (wr_addr   == '0);

  // register array: reset clears everything, writes to a hardwired r0 drop
  always_ff @(posedge clk) begin
    if (reset)
      rf <= '0;
    else if (wr_en && !zero_wr)
      rf[wr_addr] <= wr_data;
  end

  lc2k_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .busy       (busy_vec),
    .any_busy   (any_busy)
  );

  // read muxes, optionally forwarding the in-flight write
  always_comb begin
    rd_data_a = zero_a ? '0 : rf[rd_addr_a];
    rd_data_b = zero_b ? '0 : rf[rd_addr_b];
    busy_a    = busy_vec[rd_addr_a];
    busy_b    = busy_vec[rd_addr_b];
`ifdef LC2K_REGFILE_WRITE_BYPASS_EN
    // a forwarded value is ready unless a new producer issues this same cycle
    if (wr_en && rd_addr_a == wr_addr && !zero_a) begin
      rd_data_a = wr_data;
      busy_a    = issue_en && (issue_addr == wr_addr);
    end
    if (wr_en && rd_addr_b == wr_addr && !zero_b) begin
      rd_data_b = wr_data;
      busy_b    = issue_en && (issue_addr == wr_addr);
    end
`endif
  end

  // debug port always shows committed state
  assign dbg_data = zero_dbg ? '0 : rf[dbg_addr];

endmodule

// File: tb/tb_lc2k_regfile_sb.sv
// Directed bench for lc2k_regfile_sb: one instance with ZERO_REG=0 and one
// with ZERO_REG=1 share all inputs; expected values are hand-computed.
module tb_lc2k_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  rd_addr_a, rd_addr_b, wr_addr, issue_addr, dbg_addr;
  logic [31:0] wr_data;
  logic        wr_en, issue_en;

  logic [31:0] rd_data_a, rd_data_b, dbg_data;
  logic        busy_a, busy_b, any_busy;
  logic [31:0] z_rd_data_a, z_rd_data_b, z_dbg_data;
  logic        z_busy_a, z_busy_b, z_any_busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  lc2k_regfile_sb #(.ZERO_REG(0)) dut (
    .clk(clk), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .busy_a(busy_a), .busy_b(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .any_busy(any_busy)
  );

  lc2k_regfile_sb #(.ZERO_REG(1)) dut_z (
    .clk(clk), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(z_rd_data_a), .rd_data_b(z_rd_data_b),
    .busy_a(z_busy_a), .busy_b(z_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .dbg_addr(dbg_addr), .dbg_data(z_dbg_data), .any_busy(z_any_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // advance one edge, then settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; issue_en = 1'b0; reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; issue_en = 1'b0;
    rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0; issue_addr = '0;
    dbg_addr = '0; wr_data = '0;

    // reset state
    tick();
    idle();
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i); rd_addr_b = 3'(i); dbg_addr = 3'(i);
      #1;
      chk($sformatf("rst_rd_a[%0d]", i), rd_data_a, 32'h0);
      chk($sformatf("rst_rd_b[%0d]", i), rd_data_b, 32'h0);
      chk($sformatf("rst_dbg[%0d]", i), dbg_data, 32'h0);
      chk($sformatf("rst_busy[%0d]", i), {30'b0, busy_a, busy_b}, 32'h0);
    end
    chk("rst_any_busy", {31'b0, any_busy}, 32'h0);

    // write r3, read same cycle then next
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'h0000_00AB;
    rd_addr_a = 3'd3; dbg_addr = 3'd3;
    #1;
`ifdef LC2K_REGFILE_WRITE_BYPASS_EN
    chk("wr_same_cycle", rd_data_a, 32'h0000_00AB);
`else
    chk("wr_same_cycle", rd_data_a, 32'h0);
`endif
    chk("dbg_no_bypass", dbg_data, 32'h0);
    tick();
    idle();
    chk("wr_next_cycle", rd_data_a, 32'h0000_00AB);
    chk("dbg_after_wr", dbg_data, 32'h0000_00AB);
    rd_addr_b = 3'd3;
    #1;
    chk("same_reg_both_ports", rd_data_b, 32'h0000_00AB);

    // issue r5, then writeback clears busy
    issue_en = 1'b1; issue_addr = 3'd5; rd_addr_a = 3'd5;
    tick();
    idle();
    chk("issue_busy_a", {31'b0, busy_a}, 32'h1);
    chk("issue_any_busy", {31'b0, any_busy}, 32'h1);
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'h0000_1234;
    tick();
    idle();
    chk("wb_busy_a", {31'b0, busy_a}, 32'h0);
    chk("wb_rd_a", rd_data_a, 32'h0000_1234);
    chk("wb_any_busy", {31'b0, any_busy}, 32'h0);

    // simultaneous issue and write to r2: new producer wins
    issue_en = 1'b1; issue_addr = 3'd2;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'h0000_0077;
    rd_addr_b = 3'd2;
    tick();
    idle();
    chk("coll_rd_b", rd_data_b, 32'h0000_0077);
    chk("coll_busy_b", {31'b0, busy_b}, 32'h1);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'h0000_0088;
    tick();
    idle();
    chk("coll_wb_busy_b", {31'b0, busy_b}, 32'h0);
    chk("coll_wb_rd_b", rd_data_b, 32'h0000_0088);

    // register 0 behaviour with and without ZERO_REG
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'hFFFF_FFFF;
    issue_en = 1'b1; issue_addr = 3'd0; rd_addr_a = 3'd0;
    #1;
    chk("z_r0_same_cycle", z_rd_data_a, 32'h0);
    tick();
    idle();
    chk("z_r0_rd", z_rd_data_a, 32'h0);
    chk("z_r0_busy", {31'b0, z_busy_a}, 32'h0);
    chk("z_any_busy", {31'b0, z_any_busy}, 32'h0);
    chk("nz_r0_rd", rd_data_a, 32'hFFFF_FFFF);
    chk("nz_r0_busy", {31'b0, busy_a}, 32'h1);

    // fill r1..r7, then reset while issuing and writing
    for (int i = 1; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 32'h1000 + 32'(i);
      tick();
    end
    idle();
    for (int i = 1; i < 8; i++) begin
      rd_addr_a = 3'(i);
      #1;
      chk($sformatf("fill_rd[%0d]", i), rd_data_a, 32'h1000 + 32'(i));
    end
    reset = 1'b1;
    issue_en = 1'b1; issue_addr = 3'd4;
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 32'h0000_DEAD;
    tick();
    idle();
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); rd_addr_a = 3'(i);
      #1;
      chk($sformatf("rst2_dbg[%0d]", i), dbg_data, 32'h0);
      chk($sformatf("rst2_busy[%0d]", i), {31'b0, busy_a}, 32'h0);
    end
    chk("rst2_any_busy", {31'b0, any_busy}, 32'h0);

    // write to formerly busy r0 after reset is an ordinary write
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'h0000_0055; rd_addr_a = 3'd0;
    tick();
    idle();
    chk("post_rst_wr_r0", rd_data_a, 32'h0000_0055);
    chk("post_rst_busy_r0", {31'b0, busy_a}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
